// File: rtl/sync_fifo_dpram_if.sv
// Handshake/bus bundle for sync_fifo_dpram: push side, pop side, status flags and error clear.
// master = the client driving push/pop requests; slave = the FIFO itself.
interface sync_fifo_dpram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_dpram.sv
// Single-clock FIFO over a simple dual-port RAM, with threshold flags, occupancy and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read port.
module sync_fifo_dpram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_dpram_if.slave     bus
);
  localparam int             DEPTH    = 2 ** ADDR_W;
  localparam int             PW       = ADDR_W + 1;
  localparam logic [PW-1:0]  DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0]  AFULL_V  = PW'(AFULL_TH);
  localparam logic [PW-1:0]  AEMPTY_V = PW'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr, cnt;
  logic              full_w, empty_w, push_ok, pop_ok;
  logic              ov_q, un_q;

  // Wrap bit makes full and empty distinguishable with a plain subtraction.
  assign cnt     = wptr - rptr;
  assign full_w  = (cnt == DEPTH_V);
  assign empty_w = (cnt == '0);
  assign push_ok = bus.wr_en && !full_w;
  assign pop_ok  = bus.rd_en && !empty_w;

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
    end
  end

  // NOTE: storage array has no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[ADDR_W-1:0]] <= bus.wr_data;
  end

  // Sticky errors: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      un_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)      ov_q <= 1'b1;
      else if (bus.clr_err)         ov_q <= 1'b0;
      if (bus.rd_en && empty_w)     un_q <= 1'b1;
      else if (bus.clr_err)         un_q <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = mem[rptr[ADDR_W-1:0]];
  assign bus.rd_valid = !empty_w;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
      if (pop_ok) rd_data_q <= mem[rptr[ADDR_W-1:0]];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.count        = cnt;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= AFULL_V);
  assign bus.almost_empty = (cnt <= AEMPTY_V);
  assign bus.overflow     = ov_q;
  assign bus.underflow    = un_q;
endmodule

// File: tb/tb_sync_fifo_dpram.sv
// Directed self-checking bench for sync_fifo_dpram (default 32-bit x 8 entries).
// Covers reset, fill/drain, sticky errors, simultaneous push/pop across wrap, and mid-stream reset.
module tb_sync_fifo_dpram;
  logic clk;
  logic rst_n;

  sync_fifo_dpram_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  sync_fifo_dpram #(
    .DATA_W(32), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q[$];
  logic [31:0] last_rd = '0;
  logic        m_ov = 1'b0;
  logic        m_un = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = q.size();
    check("count",        bus.count,        64'(n));
    check("empty",        bus.empty,        64'(n == 0));
    check("full",         bus.full,         64'(n == 8));
    check("almost_full",  bus.almost_full,  64'(n >= 6));
    check("almost_empty", bus.almost_empty, 64'(n <= 2));
    check("overflow",     bus.overflow,     64'(m_ov));
    check("underflow",    bus.underflow,    64'(m_un));
  endtask

  // One clock: drive request, advance one edge, update the reference queue and compare.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic c);
    int   n;
    logic push_ok, pop_ok;
    n       = q.size();
    push_ok = w && (n < 8);
    pop_ok  = r && (n > 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_valid", bus.rd_valid, 64'(n > 0));
    if (n > 0) check("fwft_data", bus.rd_data, 64'(q[0]));
`endif
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    if (pop_ok)  last_rd = q.pop_front();
    if (push_ok) q.push_back(d);
    m_ov = (w && n == 8) ? 1'b1 : (c ? 1'b0 : m_ov);
    m_un = (r && n == 0) ? 1'b1 : (c ? 1'b0 : m_un);
`ifndef SYNC_FIFO_FWFT_EN
    check("rd_valid", bus.rd_valid, 64'(pop_ok));
    check("rd_data",  bus.rd_data,  64'(last_rd));
`endif
    check_flags();
  endtask

  task automatic check_reset_outputs();
    check("rst_count",  bus.count,        64'd0);
    check("rst_empty",  bus.empty,        64'd1);
    check("rst_aempty", bus.almost_empty, 64'd1);
    check("rst_full",   bus.full,         64'd0);
    check("rst_afull",  bus.almost_full,  64'd0);
    check("rst_ov",     bus.overflow,     64'd0);
    check("rst_un",     bus.underflow,    64'd0);
    check("rst_valid",  bus.rd_valid,     64'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_data",   bus.rd_data,      64'd0);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    #12;
    rst_n = 1'b1;
    check_reset_outputs();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill 0xA0..0xA7; per-cycle flag checks cover almost_full at 6 and full at 8.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);

    // Push while full: rejected, overflow sticks across an idle cycle.
    cycle(1'b1, 32'hFF, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b0, 1'b0);

    // Drain: 0xA0 comes back first, proving the 0xFF push did not touch slot 0.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("drain_order", last_rd, 64'(32'hA0 + 32'(i)));
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b0, 32'h0, 1'b0, 1'b1);   // clear overflow
    cycle(1'b0, 32'h0, 1'b1, 1'b0);   // pop while empty -> underflow
    cycle(1'b0, 32'h0, 1'b0, 1'b1);   // clear underflow

    // Preload 4, then 20 push+pop cycles wrap both pointers with count held at 4.
    for (int i = 0; i < 4; i++)  cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)  cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);

    // Full with push+pop: pop wins, count 7, overflow set.
    cycle(1'b1, 32'hDEAD, 1'b1, 1'b0);
    check("full_pp_count", bus.count, 64'd7);
    check("full_pp_ov",    bus.overflow, 64'd1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Empty with push+pop: push wins, count 1, underflow set.
    cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
    check("empty_pp_count", bus.count, 64'd1);
    check("empty_pp_un",    bus.underflow, 64'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);

    // Three pushes, then an async reset pulse between edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    last_rd = '0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    #2 rst_n = 1'b1;
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b1, 1'b0);
    check("post_rst_data", last_rd, 64'h55);

    // Fall-through visibility: 0x11 visible with no rd_en, 0x22 next after one pop.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_11_valid", bus.rd_valid, 64'd1);
    check("fwft_11_data",  bus.rd_data,  64'h11);
`endif
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b0, 32'h0,  1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_22_valid", bus.rd_valid, 64'd1);
    check("fwft_22_data",  bus.rd_data,  64'h22);
`else
    check("reg_11_data",   bus.rd_data,  64'h11);
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
